uart_fifo_core: RTL and testbench

Parametrised UART core with independent TX and RX FIFOs. Frame format is programmable at run time: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits, 16-bit baud divider. Sticky error flags and a level interrupt are provided. It sits behind the bus-specific wrappers (simple, APB, AHB, Avalon) as their common datapath. It drives the serial pins that the UART bench monitors through its UART interface.

---
 rtl/uart_fifo_core.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// UART datapath shared by the bus wrappers: TX/RX FIFOs, run-time frame format,
// 16x-free single-sample receiver, sticky errors and a level interrupt.

module uart_fifo_core_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push_c, do_pop_c;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign do_pop_c  = pop_i & ~empty_o;
  // a pop frees the slot, so a push into a full FIFO is accepted in that cycle
  assign do_push_c = push_i & (~full_o | do_pop_c);
  assign data_o    = mem_q[rd_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push_c) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop_c) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push_c) - CW'(do_pop_c);
    end
  end
endmodule

module uart_fifo_core #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_dbits,
  input  logic [1:0]       cfg_par,
  input  logic             cfg_stop2,
  input  logic             tx_en,
  input  logic             rx_en,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic             err_clr,
  output logic             uart_tx,
  input  logic             uart_rx,
  output logic             tx_busy,
  output logic             rx_overrun,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             irq
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  logic [DIV_W-1:0] div_eff_c, rx_period_c;
  logic [2:0]       last_bit_c;
  logic [7:0]       dmask_c, tx_head_c, tx_load_c;
  logic             par_en_c, par_odd_c;

  assign div_eff_c  = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
  assign last_bit_c = {1'b0, cfg_dbits} + 3'd4;
  assign dmask_c    = 8'hFF >> (2'd3 - cfg_dbits);
  assign par_en_c   = (cfg_par == 2'd1) || (cfg_par == 2'd2);
  assign par_odd_c  = (cfg_par == 2'd2);

  // ---------------- TX ----------------
  state_e           tx_state_q;
  logic [DIV_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_shift_q;
  logic             tx_par_q, tx_stop2_q, uart_tx_q, tx_busy_q;
  logic             tx_empty_c, tx_full_c, tx_tick_c, tx_pop_c;

  uart_fifo_core_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push_i(tx_valid), .pop_i(tx_pop_c), .data_i(tx_data),
    .data_o(tx_head_c), .empty_o(tx_empty_c), .full_o(tx_full_c)
  );

  assign tx_tick_c = (tx_cnt_q >= div_eff_c - DIV_W'(1));
  assign tx_load_c = tx_head_c & dmask_c;
  // load from IDLE, or straight out of the last stop period for gapless frames
  assign tx_pop_c  = tx_en & ~tx_empty_c &
                     ((tx_state_q == S_IDLE) || ((tx_state_q == S_STOP) && tx_tick_c && !tx_stop2_q));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_stop2_q <= 1'b0;
      uart_tx_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_cnt_q <= tx_tick_c ? '0 : tx_cnt_q + DIV_W'(1);
      case (tx_state_q)
        S_IDLE: tx_cnt_q <= '0;
        S_START: if (tx_tick_c) begin
          tx_state_q <= S_DATA;
          tx_bit_q   <= '0;
          uart_tx_q  <= tx_shift_q[0];
        end
        S_DATA: if (tx_tick_c) begin
          if (tx_bit_q >= last_bit_c) begin
            if (par_en_c) begin
              tx_state_q <= S_PARITY;
              uart_tx_q  <= tx_par_q;
            end else begin
              tx_state_q <= S_STOP;
              uart_tx_q  <= 1'b1;
              tx_stop2_q <= cfg_stop2;
            end
          end else begin
            tx_bit_q   <= tx_bit_q + 3'd1;
            tx_shift_q <= tx_shift_q >> 1;
            uart_tx_q  <= tx_shift_q[1];
          end
        end
        S_PARITY: if (tx_tick_c) begin
          tx_state_q <= S_STOP;
          uart_tx_q  <= 1'b1;
          tx_stop2_q <= cfg_stop2;
        end
        S_STOP: if (tx_tick_c) begin
          if (tx_stop2_q) tx_stop2_q <= 1'b0;
          else begin
            tx_state_q <= S_IDLE;
            tx_busy_q  <= 1'b0;
            uart_tx_q  <= 1'b1;
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
      if (tx_pop_c) begin
        tx_state_q <= S_START;
        tx_cnt_q   <= '0;
        tx_shift_q <= tx_load_c;
        tx_par_q   <= (^tx_load_c) ^ par_odd_c;
        uart_tx_q  <= 1'b0;
        tx_busy_q  <= 1'b1;
      end
    end
  end

  // ---------------- RX ----------------
  state_e           rx_state_q;
  logic [DIV_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic             rx_s1_q, rx_s2_q, rx_s3_q, rx_par_q, rx_perr_q;
  logic             rx_empty_c, rx_full_c, rx_tick_c, rx_done_c, rx_pop_c;

  assign rx_pop_c    = rx_ready & ~rx_empty_c;
  assign rx_period_c = (rx_state_q == S_START) ? (div_eff_c >> 1) : div_eff_c;
  assign rx_tick_c   = (rx_cnt_q >= rx_period_c - DIV_W'(1));
  assign rx_done_c   = (rx_state_q == S_STOP) && rx_tick_c;

  uart_fifo_core_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push_i(rx_done_c), .pop_i(rx_pop_c), .data_i(rx_shift_q),
    .data_o(rx_data), .empty_o(rx_empty_c), .full_o(rx_full_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_s1_q  <= uart_rx;
      rx_s2_q  <= rx_s1_q;
      rx_s3_q  <= rx_s2_q;
      rx_cnt_q <= rx_tick_c ? '0 : rx_cnt_q + DIV_W'(1);
      case (rx_state_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_en && !rx_s2_q && rx_s3_q) begin
            rx_state_q <= S_START;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
          end
        end
        // mid-start re-sample rejects glitches shorter than half a bit
        S_START: if (rx_tick_c) begin
          rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
          rx_bit_q   <= '0;
        end
        S_DATA: if (rx_tick_c) begin
          rx_shift_q[rx_bit_q] <= rx_s2_q;
          rx_par_q             <= rx_par_q ^ rx_s2_q;
          if (rx_bit_q >= last_bit_c) rx_state_q <= par_en_c ? S_PARITY : S_STOP;
          else rx_bit_q <= rx_bit_q + 3'd1;
        end
        S_PARITY: if (rx_tick_c) begin
          rx_perr_q  <= rx_par_q ^ rx_s2_q ^ par_odd_c;
          rx_state_q <= S_STOP;
        end
        S_STOP: if (rx_tick_c) rx_state_q <= S_IDLE;
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // sticky errors: a new error wins over a same-cycle clear
  logic ovr_q, perr_q, ferr_q, irq_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovr_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      irq_q  <= 1'b1;
    end else begin
      ovr_q  <= (ovr_q & ~err_clr) | (rx_done_c & rx_full_c & ~rx_pop_c);
      perr_q <= (perr_q & ~err_clr) | (rx_done_c & rx_perr_q & par_en_c);
      ferr_q <= (ferr_q & ~err_clr) | (rx_done_c & ~rx_s2_q);
      irq_q  <= ~rx_empty_c | ovr_q | perr_q | ferr_q | (tx_empty_c & ~tx_busy_q);
    end
  end

  assign tx_ready      = ~tx_full_c;
  assign rx_valid      = ~rx_empty_c;
  assign uart_tx       = uart_tx_q;
  assign tx_busy       = tx_busy_q;
  assign rx_overrun    = ovr_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign irq           = irq_q;
endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core: TX waveform checks, loopback and driven RX frames.

module tb_uart_fifo_core;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DIV_W = 16;
  localparam int          DIV   = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic [DIV_W-1:0] cfg_div;
  logic [1:0]       cfg_dbits, cfg_par;
  logic             cfg_stop2, tx_en, rx_en, tx_valid, rx_ready, err_clr;
  logic [7:0]       tx_data, rx_data;
  logic             tx_ready, rx_valid, uart_tx, uart_rx, tx_busy;
  logic             rx_overrun, rx_parity_err, rx_frame_err, irq;
  logic             rx_drv, loop;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;
  assign uart_rx = loop ? uart_tx : rx_drv;

  uart_fifo_core #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rstn(rstn), .cfg_div(cfg_div), .cfg_dbits(cfg_dbits), .cfg_par(cfg_par),
    .cfg_stop2(cfg_stop2), .tx_en(tx_en), .rx_en(rx_en), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .err_clr(err_clr), .uart_tx(uart_tx), .uart_rx(uart_rx),
    .tx_busy(tx_busy), .rx_overrun(rx_overrun), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .irq(irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // pops happen on the next posedge when rx_valid & rx_ready
  always @(negedge clk) begin
    if (rstn && rx_valid && rx_ready) begin
      check_eq("rx_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check_eq("rx_data", 32'(rx_data), 32'(sb.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] d, input int nb, input int pmode,
                             input bit flip, input bit stop_v);
    bit p;
    p = 1'b0;
    rx_drv = 1'b0;
    tick(DIV);
    for (int i = 0; i < nb; i++) begin
      rx_drv = d[i];
      p ^= d[i];
      tick(DIV);
    end
    if (pmode != 0) begin
      rx_drv = p ^ (pmode == 2) ^ flip;
      tick(DIV);
    end
    rx_drv = stop_v;
    tick(DIV);
    rx_drv = 1'b1;
    tick(2 * DIV);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && (sb.size() != 0 || rx_valid); i++) tick(1);
    check_eq("drain", 32'(sb.size()), 32'd0);
    tick(2 * DIV);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [9:0] frame;
    int         n;
    rstn = 1'b0; cfg_div = DIV_W'(DIV); cfg_dbits = 2'd3; cfg_par = 2'd0; cfg_stop2 = 1'b0;
    tx_en = 1'b1; rx_en = 1'b1; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
    err_clr = 1'b0; rx_drv = 1'b1; loop = 1'b0;
    tick(3);
    check_eq("rst_uart_tx", 32'(uart_tx), 32'd1);
    check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_errs", 32'({rx_overrun, rx_parity_err, rx_frame_err}), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd1);
    rstn = 1'b1;
    tick(2);

    // basic 8N1 TX of 0xA5, every clock of the frame checked
    frame = {1'b1, 8'hA5, 1'b0};
    push_tx(8'hA5);
    tick(1);
    for (int c = 0; c < 40; c++) begin
      check_eq("tx_bit", 32'(uart_tx), 32'(frame[c / DIV]));
      check_eq("tx_busy", 32'(tx_busy), 32'd1);
      if (c == 20) check_eq("irq_busy", 32'(irq), 32'd0);
      tick(1);
    end
    check_eq("tx_busy_end", 32'(tx_busy), 32'd0);
    check_eq("tx_idle", 32'(uart_tx), 32'd1);
    tick(1);
    check_eq("irq_tx_empty", 32'(irq), 32'd1);
    tick(4);

    // 7E1 / 7O1 loopback of 0x55
    loop = 1'b1; cfg_dbits = 2'd2;
    for (int k = 1; k <= 2; k++) begin
      cfg_par = 2'(k);
      sb.push_back(8'h55);
      push_tx(8'h55);
      tick(35);
      check_eq(k == 1 ? "tx_par_even" : "tx_par_odd", 32'(uart_tx), 32'(k - 1));
      wait_drain(200);
      check_eq("par_errs", 32'({rx_overrun, rx_parity_err, rx_frame_err}), 32'd0);
    end

    // TX FIFO full, then gapless burst looped back
    cfg_dbits = 2'd3; cfg_par = 2'd0; tx_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check_eq("tx_full", 32'(tx_ready), 32'd0);
      else sb.push_back(8'(8'h10 + i));
      push_tx(8'(8'h10 + i));
    end
    tx_en = 1'b1;
    for (int i = 0; i < 10 && !tx_busy; i++) tick(1);
    n = 0;
    while (tx_busy && n < 400) begin
      n++;
      tick(1);
    end
    check_eq("b2b_busy_clocks", 32'(n), 32'd320);
    wait_drain(200);
    check_eq("no_9th_frame", 32'(tx_busy), 32'd0);

    // RX overrun: 9 frames into an 8-deep FIFO
    loop = 1'b0; rx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) sb.push_back(8'(i));
      drive_frame(8'(i), 8, 0, 1'b0, 1'b1);
    end
    check_eq("overrun", 32'(rx_overrun), 32'd1);
    check_eq("ovr_rx_valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    wait_drain(100);
    check_eq("ovr_empty", 32'(rx_valid), 32'd0);
    pulse_clr();
    check_eq("overrun_clr", 32'(rx_overrun), 32'd0);

    // framing error: byte still delivered
    sb.push_back(8'h3A);
    drive_frame(8'h3A, 8, 0, 1'b0, 1'b0);
    wait_drain(100);
    check_eq("frame_err", 32'({rx_parity_err, rx_frame_err}), 32'b01);
    check_eq("irq_err", 32'(irq), 32'd1);
    pulse_clr();

    // parity error with 8E1
    cfg_par = 2'd1;
    sb.push_back(8'h0F);
    drive_frame(8'h0F, 8, 1, 1'b1, 1'b1);
    wait_drain(100);
    check_eq("parity_err", 32'({rx_parity_err, rx_frame_err}), 32'b10);
    pulse_clr();
    check_eq("errs_clr", 32'({rx_overrun, rx_parity_err, rx_frame_err}), 32'd0);

    // 1-clock glitch in IDLE must not start a frame
    cfg_par = 2'd0;
    rx_drv = 1'b0;
    tick(1);
    rx_drv = 1'b1;
    tick(60);
    check_eq("glitch_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("glitch_errs", 32'({rx_overrun, rx_parity_err, rx_frame_err}), 32'd0);

    // asynchronous reset in the DATA state, then a clean frame
    push_tx(8'h3C);
    repeat (6) @(posedge clk);
    #3;
    check_eq("pre_rst_low", 32'(uart_tx), 32'd0);
    rstn = 1'b0;
    #1;
    check_eq("rst_mid_tx", 32'(uart_tx), 32'd1);
    check_eq("rst_mid_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_mid_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_mid_irq", 32'(irq), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    tick(2);
    check_eq("rst_fifo_empty", 32'(tx_busy), 32'd0);
    loop = 1'b1;
    sb.push_back(8'h3C);
    push_tx(8'h3C);
    wait_drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
